// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble scheduler: load-use interlock, divider start/busy sequencing, dcache wait hold.
// Outputs are combinational from registered state and same-cycle inputs; any hold wins over issue.
module hazard_stall_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_ReadRs,
  input  logic       ID_ReadRt,
  input  logic [4:0] EXE_Dst,
  input  logic       EXE_RFWr,
  input  logic       EXE_IsLoad,
  input  logic       EXE_IsDiv,
  input  logic       MEM_ReqValid,
  input  logic       MEM_DataOK,
  input  logic       Exc_Flush,
  output logic       IF_Stall,
  output logic       ID_Stall,
  output logic       EXE_Stall,
  output logic       MEM_Stall,
  output logic       EXE_Bubble,
  output logic       MEM_Bubble,
  output logic       Div_Start,
  output logic       Div_Busy
);

  localparam int CW = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  div_state_e    div_state_q, div_state_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          pend_q, pend_d;

  logic mem_wait;
  logic load_use;
  logic div_start;
  logic div_hold;

  // A same-cycle DataOK both ends the wait and prevents pend from being set.
  always_comb begin
    mem_wait = (MEM_ReqValid | pend_q) & ~MEM_DataOK;
    pend_d   = pend_q;
    if (MEM_DataOK) begin
      pend_d = 1'b0;
    end else if (MEM_ReqValid) begin
      pend_d = 1'b1;
    end
  end

  always_comb begin
    load_use = EXE_IsLoad & EXE_RFWr & (EXE_Dst != 5'd0) &
               ((ID_ReadRs & (ID_rs == EXE_Dst)) | (ID_ReadRt & (ID_rt == EXE_Dst)));
  end

  // The counter keeps running under a memory wait; only a flush aborts a divide.
  always_comb begin
    div_state_d = div_state_q;
    div_cnt_d   = div_cnt_q;
    div_start   = 1'b0;
    div_hold    = 1'b0;
    case (div_state_q)
      S_IDLE: begin
        if (EXE_IsDiv & ~mem_wait & ~Exc_Flush) begin
          div_start   = 1'b1;
          div_hold    = 1'b1;
          div_state_d = S_BUSY;
          div_cnt_d   = CW'(DIV_CYCLES - 1);
        end
      end
      S_BUSY: begin
        div_hold = 1'b1;
        if (Exc_Flush) begin
          div_state_d = S_IDLE;
          div_cnt_d   = '0;
        end else if (div_cnt_q == '0) begin
          div_state_d = S_DONE;
        end else begin
          div_cnt_d = div_cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        div_state_d = S_IDLE;
        div_cnt_d   = '0;
      end
      default: begin
        div_state_d = S_IDLE;
        div_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_state_q <= S_IDLE;
      div_cnt_q   <= '0;
      pend_q      <= 1'b0;
    end else begin
      div_state_q <= div_state_d;
      div_cnt_q   <= div_cnt_d;
      pend_q      <= pend_d;
    end
  end

  // Gating with resetn keeps live inputs from leaking through while in reset.
  always_comb begin
    IF_Stall   = 1'b0;
    ID_Stall   = 1'b0;
    EXE_Stall  = 1'b0;
    MEM_Stall  = 1'b0;
    EXE_Bubble = 1'b0;
    MEM_Bubble = 1'b0;
    Div_Start  = 1'b0;
    Div_Busy   = 1'b0;
    if (resetn) begin
      Div_Start = div_start;
      Div_Busy  = (div_state_q == S_BUSY);
      if (Exc_Flush) begin
        EXE_Bubble = 1'b1;
        MEM_Bubble = 1'b1;
      end else if (mem_wait) begin
        IF_Stall  = 1'b1;
        ID_Stall  = 1'b1;
        EXE_Stall = 1'b1;
        MEM_Stall = 1'b1;
      end else if (div_hold) begin
        IF_Stall   = 1'b1;
        ID_Stall   = 1'b1;
        EXE_Stall  = 1'b1;
        MEM_Bubble = 1'b1;
      end else if (load_use) begin
        IF_Stall   = 1'b1;
        ID_Stall   = 1'b1;
        EXE_Bubble = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with a cycle-level reference model and literal checkpoints.
// Output vector order: {IF_Stall, ID_Stall, EXE_Stall, MEM_Stall, EXE_Bubble, MEM_Bubble, Div_Start, Div_Busy}.
module tb_hazard_stall_ctrl;

  localparam int N = 4;

  localparam logic [7:0] NONE  = 8'b0000_0000;
  localparam logic [7:0] LU_O  = 8'b1100_1000;
  localparam logic [7:0] MW_O  = 8'b1111_0000;
  localparam logic [7:0] DIV_S = 8'b1110_0110;
  localparam logic [7:0] DIV_B = 8'b1110_0101;
  localparam logic [7:0] MW_B  = 8'b1111_0001;
  localparam logic [7:0] FL_B  = 8'b0000_1101;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] ID_rs, ID_rt, EXE_Dst;
  logic       ID_ReadRs, ID_ReadRt, EXE_RFWr, EXE_IsLoad, EXE_IsDiv;
  logic       MEM_ReqValid, MEM_DataOK, Exc_Flush;
  logic       IF_Stall, ID_Stall, EXE_Stall, MEM_Stall;
  logic       EXE_Bubble, MEM_Bubble, Div_Start, Div_Busy;
  logic [7:0] out_v;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.DIV_CYCLES(N)) dut (
    .clk(clk), .resetn(resetn),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_ReadRs(ID_ReadRs), .ID_ReadRt(ID_ReadRt),
    .EXE_Dst(EXE_Dst), .EXE_RFWr(EXE_RFWr), .EXE_IsLoad(EXE_IsLoad), .EXE_IsDiv(EXE_IsDiv),
    .MEM_ReqValid(MEM_ReqValid), .MEM_DataOK(MEM_DataOK), .Exc_Flush(Exc_Flush),
    .IF_Stall(IF_Stall), .ID_Stall(ID_Stall), .EXE_Stall(EXE_Stall), .MEM_Stall(MEM_Stall),
    .EXE_Bubble(EXE_Bubble), .MEM_Bubble(MEM_Bubble), .Div_Start(Div_Start), .Div_Busy(Div_Busy)
  );

  assign out_v = {IF_Stall, ID_Stall, EXE_Stall, MEM_Stall, EXE_Bubble, MEM_Bubble, Div_Start, Div_Busy};

  // Model state: busy cycles still to run, whether the release cycle is current, outstanding dcache miss.
  int m_left = 0;
  bit m_done = 1'b0;
  bit m_pend = 1'b0;

  function automatic bit model_mw();
    return (MEM_ReqValid || m_pend) && !MEM_DataOK;
  endfunction

  function automatic bit model_start();
    return (m_left == 0) && !m_done && EXE_IsDiv && !model_mw() && !Exc_Flush;
  endfunction

  function automatic logic [7:0] model_out();
    logic [7:0] o;
    bit lu;
    o = NONE;
    if (!resetn) return o;
    lu = EXE_IsLoad && EXE_RFWr && (EXE_Dst != 0) &&
         ((ID_ReadRs && ID_rs == EXE_Dst) || (ID_ReadRt && ID_rt == EXE_Dst));
    if (Exc_Flush)                        o = 8'b0000_1100;
    else if (model_mw())                  o = 8'b1111_0000;
    else if (model_start() || m_left > 0) o = 8'b1110_0100;
    else if (lu)                          o = 8'b1100_1000;
    o[1] = model_start();
    o[0] = (m_left > 0);
    return o;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_pend <= 1'b0;
    end else begin
      if (Exc_Flush) begin
        m_left <= 0;
        m_done <= 1'b0;
      end else if (model_start()) begin
        m_left <= N;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        m_done <= (m_left == 1);
      end else begin
        m_done <= 1'b0;
      end
      if (MEM_DataOK)        m_pend <= 1'b0;
      else if (MEM_ReqValid) m_pend <= 1'b1;
    end
  end

  always @(negedge clk) begin : cmp
    logic [7:0] e;
    e = model_out();
    total++;
    if (out_v !== e) begin
      bad++;
      $display("FAIL model_cmp t=%0t got=%b want=%b", $time, out_v, e);
    end
    if (resetn && Exc_Flush) begin
      total++;
      if (model_mw()) begin
        bad++;
        $display("FAIL flush_during_memwait t=%0t got=flush want=no_flush", $time);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, exp);
    end
  endtask

  task automatic idle_in();
    ID_rs = 0; ID_rt = 0; ID_ReadRs = 0; ID_ReadRt = 0;
    EXE_Dst = 0; EXE_RFWr = 0; EXE_IsLoad = 0; EXE_IsDiv = 0;
    MEM_ReqValid = 0; MEM_DataOK = 0; Exc_Flush = 0;
  endtask

  task automatic set_load(input logic [4:0] dst);
    EXE_IsLoad = 1; EXE_RFWr = 1; EXE_Dst = dst;
  endtask

  // Check at mid-cycle, then move to just after the next rising edge.
  task automatic look(input string name, input logic [7:0] exp);
    @(negedge clk); #1;
    chk(name, out_v, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    idle_in();
    #1;
    EXE_IsDiv = 1;
    look("reset_div_in", NONE);
    idle_in();
    resetn = 1;
    look("idle_after_reset", NONE);

    set_load(5); ID_rs = 5; ID_ReadRs = 1;
    look("lu_rs", LU_O);
    idle_in();
    look("lu_rs_released", NONE);
    set_load(0); ID_rs = 0; ID_ReadRs = 1;
    look("lu_r0", NONE);
    idle_in(); set_load(7); ID_rt = 7; ID_ReadRt = 1;
    look("lu_rt", LU_O);
    ID_ReadRt = 0;
    look("lu_rt_unread", NONE);
    ID_ReadRt = 1; EXE_RFWr = 0;
    look("lu_no_wr", NONE);
    idle_in();

    EXE_IsDiv = 1;
    look("div_start", DIV_S);
    look("div_busy1", DIV_B);
    set_load(5); ID_rs = 5; ID_ReadRs = 1;
    look("div_busy2_lu_masked", DIV_B);
    idle_in(); EXE_IsDiv = 1;
    look("div_busy3", DIV_B);
    look("div_busy4", DIV_B);
    look("div_done_no_restart", NONE);
    EXE_IsDiv = 0;
    look("div_after", NONE);

    MEM_ReqValid = 1;
    look("miss_t0", MW_O);
    MEM_ReqValid = 0;
    look("miss_t1", MW_O);
    look("miss_t2", MW_O);
    MEM_DataOK = 1;
    look("miss_t3", NONE);
    MEM_DataOK = 0;
    look("miss_t4", NONE);
    MEM_ReqValid = 1; MEM_DataOK = 1;
    look("hit", NONE);
    idle_in();
    look("hit_after", NONE);

    EXE_IsDiv = 1;
    look("fl_start", DIV_S);
    look("fl_busy1", DIV_B);
    Exc_Flush = 1;
    look("fl_busy2_flush", FL_B);
    idle_in();
    look("fl_idle", NONE);

    EXE_IsDiv = 1;
    look("ov_start", DIV_S);
    MEM_ReqValid = 1;
    look("ov_busy1_miss", MW_B);
    MEM_ReqValid = 0;
    look("ov_busy2_pend", MW_B);
    MEM_DataOK = 1;
    look("ov_busy3_ok", DIV_B);
    MEM_DataOK = 0;
    look("ov_busy4", DIV_B);
    look("ov_done", NONE);
    EXE_IsDiv = 0;
    look("ov_after", NONE);

    EXE_IsDiv = 1;
    look("rs_start", DIV_S);
    look("rs_busy1", DIV_B);
    #2;
    resetn = 0;
    #1;
    chk("rst_async_immediate", out_v, NONE);
    look("rst_hold", NONE);
    resetn = 1;
    look("rs_fresh_start", DIV_S);
    EXE_IsDiv = 0;
    for (int i = 0; i < N; i++) look("rs_busy", DIV_B);
    look("rs_done", NONE);
    look("end_idle", NONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central stall/bubble scheduler for the 5-stage MIPS pipeline.
- Detects load-use hazards that EXE-stage forwarding cannot cover.
- Sequences the multi-cycle divider with a start/busy FSM.
- Holds the pipeline while a data-cache access is outstanding.
- Produces per-stage stall and bubble controls consumed by the pipeline registers. The forwarding mux selects keep operating on the held register contents.

Parameters:
DIV_CYCLES, 32, divider iterations after start; counter width $clog2(DIV_CYCLES); legal range 2..64.

Ports:
clk  in  1  pipeline clock
resetn  in  1  asynchronous active-low reset
ID_rs  in  5  rs index of instruction in ID
ID_rt  in  5  rt index of instruction in ID
ID_ReadRs  in  1  ID instruction reads rs
ID_ReadRt  in  1  ID instruction reads rt
EXE_Dst  in  5  destination register of instruction in EXE
EXE_RFWr  in  1  EXE instruction writes register file
EXE_IsLoad  in  1  EXE instruction is a load
EXE_IsDiv  in  1  EXE instruction is DIV/DIVU
MEM_ReqValid  in  1  MEM stage issues dcache request this cycle
MEM_DataOK  in  1  dcache data/ack returned this cycle
Exc_Flush  in  1  exception/eret flush of IF..EXE
IF_Stall  out  1  hold PC and IF/ID register
ID_Stall  out  1  hold ID/EXE inputs
EXE_Stall  out  1  hold EXE/MEM inputs
MEM_Stall  out  1  hold MEM/WB inputs
EXE_Bubble  out  1  load NOP into ID/EXE register
MEM_Bubble  out  1  load NOP into EXE/MEM register
Div_Start  out  1  one-cycle start pulse to divider
Div_Busy  out  1  divider FSM in BUSY

Behaviour:
- Reset (resetn low, async): div FSM = IDLE, div counter = 0, mem pending flag = 0. All outputs are 0 while resetn is low.
- Outputs are combinational from registered state and the current-cycle inputs. State updates on the rising edge of clk.
- Mem wait:
  - MemWait = (MEM_ReqValid | pend) & ~MEM_DataOK.
  - pend sets on MEM_ReqValid & ~MEM_DataOK and clears on MEM_DataOK.
  - DataOK in the same cycle as ReqValid gives zero stall cycles.
  - Exc_Flush while MemWait=1 is illegal; the bench asserts this.
- Divider FSM states IDLE, BUSY, DONE:
  - IDLE: if EXE_IsDiv & ~MemWait & ~Exc_Flush, then Div_Start=1 and DivHold=1; next state BUSY with cnt=DIV_CYCLES-1.
  - BUSY: Div_Busy=1, DivHold=1, cnt decrements every cycle. When cnt==0, next state is DONE. A MemWait in BUSY does not pause cnt.
  - DONE: DivHold=0; the divide result is valid and the instruction advances; next state IDLE. DONE never raises Div_Start, even if EXE_IsDiv is still 1.
  - Exc_Flush in BUSY or DONE forces next state IDLE, cnt=0, Div_Start=0.
  - Total hold = DIV_CYCLES+1 cycles from first EXE cycle to release.
- Load-use:
  - LU = EXE_IsLoad & EXE_RFWr & (EXE_Dst!=0) & ((ID_ReadRs & ID_rs==EXE_Dst) | (ID_ReadRt & ID_rt==EXE_Dst)).
  - Register $0 never causes a hazard.
- Priority, evaluated each cycle:
  1. Exc_Flush: all stalls 0; EXE_Bubble=1, MEM_Bubble=1.
  2. MemWait: IF/ID/EXE/MEM_Stall=1, no bubbles.
  3. DivHold: IF/ID/EXE_Stall=1, MEM_Bubble=1, MEM_Stall=0.
  4. LU: IF/ID_Stall=1, EXE_Bubble=1; EXE/MEM proceed.
  5. Otherwise all 0.
- Simultaneous conditions:
  - LU during DivHold is not signalled; it is re-evaluated when the hold releases.
  - Stall and bubble are never both asserted for the same register: EXE_Bubble implies ~EXE_Stall, and MEM_Bubble implies ~MEM_Stall.
- Reset mid-divide returns the FSM to IDLE immediately; no Div_Start is issued until resetn is high and a new EXE_IsDiv is seen.

Test Plan:
- Load-use on rs: EXE lw $5 (EXE_IsLoad=1, EXE_RFWr=1, EXE_Dst=5), ID reads rs=5 → exactly 1 cycle of IF_Stall=ID_Stall=EXE_Bubble=1. Same with EXE_Dst=0 → no stall.
- DIV with DIV_CYCLES=4, EXE_IsDiv held → Div_Start high only in the first cycle; IF/ID/EXE_Stall and MEM_Bubble high for 5 cycles; Div_Busy high for 4 cycles; released in DONE; no second Div_Start.
- Dcache miss: MEM_ReqValid pulse at t0, MEM_DataOK at t3 → all four stalls high during t0..t2, low at t3. Hit with DataOK at t0 → 0 stall cycles.
- Exc_Flush at BUSY cycle 2 → next cycle FSM is IDLE and Div_Busy=0; the flush cycle shows EXE_Bubble=MEM_Bubble=1 and all stalls 0.
- Overlap: mem miss begins while div BUSY (DIV_CYCLES=4) → MEM_Stall follows MemWait; divider still releases at cycle 5; MEM_Bubble is suppressed while MemWait=1.
- Async reset asserted mid-BUSY → outputs 0 immediately; after release, EXE_IsDiv=1 produces a fresh Div_Start.
